sha256_core_arbiter: RTL and testbench
======================================

# sha256_core_arbiter

Round-robin arbiter that shares one `sha256` compression core between `NREQ` requesters, such as the HMAC/PBKDF2 stages of the scrypt pipeline. Each requester submits one 512-bit message block together with its own 256-bit chaining value. The arbiter latches the job, runs it on the core, and returns the 256-bit result with a one-cycle done pulse to the owning requester. Each requester keeps its own chaining state, so jobs from different requesters may interleave freely between blocks.

## Interface
- `NREQ`, default 4: number of requesters, ≥2.
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `req` in NREQ: per-requester job request. Held high until the matching `gnt`.
- `req_data` in NREQ*512: message block. Requester i uses `[i*512 +: 512]`.
- `req_chain` in NREQ*256: chaining value. Requester i uses `[i*256 +: 256]`.
- `gnt` out NREQ: one-hot, one-cycle pulse. The job has been latched.
- `done` out NREQ: one-hot, one-cycle pulse. `hash_out` is valid for that requester.
- `hash_out` out 256: last completed hash. Holds until the next completion.
- `busy` out 1: high whenever state ≠ IDLE.
- `sha_enable` out 1: core enable.
- `sha_data` out 512: core message block.
- `sha_current_hash` out 256: core chaining input.
- `sha_hash` in 256: core result.
- `sha_done` in 1: core one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, RELEASE.
- **IDLE**
  - `sha_enable`=0.
  - If any `req` bit is high, select the owner by round-robin. The search starts at `(last+1) mod NREQ`.
  - Latch `req_data` and `req_chain` of the owner into internal job registers.
  - Register `gnt[owner]`=1 and go to RUN.
  - If `req`==0, stay in IDLE.
- **RUN**
  - `sha_enable`=1.
  - `sha_data` and `sha_current_hash` are driven from the job registers and stay stable for the whole state.
  - On `sha_done`=1: `hash_out`<=`sha_hash`, `done[owner]`<=1, `last`<=owner, go to RELEASE.
- **RELEASE**
  - `sha_enable`=0 for exactly one cycle, so every job is a distinct enable assertion to the core.
  - Go to IDLE unconditionally.
- **Request sampling**
  - `req` is sampled only in IDLE.
  - A request raised in RUN or RELEASE waits; it is never lost while held.
  - A requester drops `req` in the cycle after it sees `gnt`. The request and data inputs are don't-care after the grant.
- **Arbitration**
  - Fairness: with all requesters continuously requesting, grants rotate 0,1,2,…,NREQ-1,0,…
  - After reset `last`=NREQ-1, so requester 0 has first priority.
- **Ignored inputs**
  - `sha_done` outside RUN is ignored: no `done`, no `hash_out` update.
- **Reset**
  - Reset values: `gnt`=0, `done`=0, `hash_out`=0, `busy`=0, `sha_enable`=0, `sha_data`=0, `sha_current_hash`=0, job registers=0, `last`=NREQ-1, state=IDLE.
  - Reset mid-RUN aborts the job with no `done`. The core shares `n_rst`.

## Timing
- `gnt` is asserted in the first RUN cycle, one cycle after the IDLE cycle that sampled `req`.
- `sha_enable` rises in that same cycle.
- `done` and `hash_out` update one cycle after the `sha_done` pulse; that cycle is RELEASE.
- Per-job overhead beyond core latency is 3 cycles: the IDLE sample cycle, the done-registration edge, and RELEASE.
- `sha_enable` is low for a minimum of 2 cycles (RELEASE and IDLE) between back-to-back jobs.
- If a requester raises `req` in its own `done` cycle, it competes in the next IDLE under the normal round-robin order. It gets no priority boost.
- `gnt` and `done` are never both high for different requesters in the same cycle. They never overlap at all, because `gnt` only occurs in the first RUN cycle and `done` only in RELEASE.

## Test plan
- **Single job, requester 2**
  - Stimulus: block = "abc" padded (`61626380 00…00 00000018`), chain = SHA-256 IV.
  - Expect `gnt`=4'b0100 for 1 cycle.
  - Expect `done`=4'b0100 for 1 cycle, with `hash_out`=`ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad`.
- **All 4 requesting continuously from reset**
  - Expect grant order 0,1,2,3,0.
  - Each `done` goes to the matching index.
  - `sha_enable` is low ≥2 cycles between jobs.
- **Data changed after grant**
  - Stimulus: requester 1 changes `req_data` to all-ones in the cycle after `gnt`.
  - Expect the result to still equal the hash of the originally latched block.
- **Spurious `sha_done` in IDLE**
  - Expect no `done` pulse, `hash_out` unchanged, state still IDLE.
- **Reset mid-RUN**
  - Stimulus: pull `n_rst` low while `sha_enable`=1.
  - Expect all outputs 0 immediately and no `done`.
  - After release, the next request from requester 3 is granted before requester 0 only if requester 0 is not requesting.
- **Two-block chained job, interleaved with another requester**
  - Requester 0 issues block 1 with the IV, then block 2 with the `hash_out` from block 1. Requester 1 issues one job in between.
  - Expect requester 0's final hash to equal the 2-block SHA-256 of the 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" = `248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1`.

Source files
------------

// File: rtl/sha256_core_arbiter.sv
// sha256_core_arbiter: round-robin sharing of one SHA-256 compression core
// among NREQ requesters, each supplying its own message block and chaining value.
module sha256_core_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*512-1:0] req_data,
    input  logic [NREQ*256-1:0] req_chain,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [255:0]        hash_out,
    output logic                busy,
    output logic                sha_enable,
    output logic [511:0]        sha_data,
    output logic [255:0]        sha_current_hash,
    input  logic [255:0]        sha_hash,
    input  logic                sha_done
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] last, owner, sel, idx;
    logic [511:0]  job_data;
    logic [255:0]  job_chain;

    // scanning from the far end leaves the nearest requester after last as the winner
    always_comb begin
        sel = last;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) sel = idx;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? RUN : IDLE;
            RUN:     state_nx = sha_done ? RELEASE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = state != IDLE;
        sha_enable = state == RUN;
    end

    assign sha_data         = job_data;
    assign sha_current_hash = job_chain;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gnt       <= '0;
            done      <= '0;
            hash_out  <= '0;
            job_data  <= '0;
            job_chain <= '0;
            owner     <= '0;
            last      <= IW'(NREQ - 1);
        end else begin
            gnt  <= '0;
            done <= '0;
            if (state == IDLE && |req) begin
                owner     <= sel;
                job_data  <= req_data[int'(sel)*512 +: 512];
                job_chain <= req_chain[int'(sel)*256 +: 256];
                gnt       <= NREQ'(1) << sel;
            end
            if (state == RUN && sha_done) begin
                hash_out <= sha_hash;
                done     <= NREQ'(1) << owner;
                last     <= owner;
            end
        end
    end
endmodule

// File: tb/tb_sha256_core_arbiter.sv
// tb_sha256_core_arbiter: drives the arbiter against a behavioural SHA-256 core
// and a cycle-level reference of the arbitration rules.
module tb_sha256_core_arbiter;
    localparam int N = 4;
    localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_H = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M2    = {480'h0, 32'h000001c0};
    localparam logic [255:0] M_H   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic [N-1:0]     req, gnt, done;
    logic [N*512-1:0] req_data;
    logic [N*256-1:0] req_chain;
    logic [255:0]     hash_out, sha_current_hash, sha_hash, core_hash, sp_hash;
    logic [511:0]     sha_data;
    logic             busy, sha_enable, sha_done, core_done, sp_done;

    assign sha_done = core_done | sp_done;
    assign sha_hash = sp_done ? sp_hash : core_hash;

    sha256_core_arbiter #(.NREQ(N)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .req_chain(req_chain),
        .gnt(gnt), .done(done), .hash_out(hash_out), .busy(busy), .sha_enable(sha_enable),
        .sha_data(sha_data), .sha_current_hash(sha_current_hash), .sha_hash(sha_hash), .sha_done(sha_done)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [511:0] blk, input logic [255:0] h);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // behavioural core: starts on each enable rise, answers after a random latency
    logic         c_act, en_d;
    int           c_cnt;
    logic [255:0] c_res;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            core_done <= 1'b0; core_hash <= '0; c_act <= 1'b0; en_d <= 1'b0; c_cnt <= 0; c_res <= '0;
        end else begin
            core_done <= 1'b0;
            en_d      <= sha_enable;
            if (c_act) begin
                if (c_cnt == 0) begin
                    core_done <= 1'b1; core_hash <= c_res; c_act <= 1'b0;
                end else c_cnt <= c_cnt - 1;
            end else if (sha_enable && !en_d) begin
                c_act <= 1'b1;
                c_cnt <= $urandom_range(0, 5);
                c_res <= sha_compress(sha_data, sha_current_hash);
            end
        end
    end

    int           n_vec = 0, n_err = 0;
    int           m_ph = 0, m_own = 0, m_last = N - 1, low_cnt = 0;
    bit           seen_en = 0;
    logic [511:0] m_jd = '0;
    logic [255:0] m_jc = '0, m_hash = '0;
    int           ngnt [N] = '{default: 0};
    int           ndone [N] = '{default: 0};
    logic [255:0] res [N];
    int           gq [$];
    logic [N-1:0] gnt_prev = '0, rearm = '0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // winner is the requester at the smallest forward distance from the previous owner
    function automatic int rr(input logic [N-1:0] r, input int lst);
        int best = -1, bd = N;
        for (int i = 0; i < N; i++)
            if (r[i] && ((i - lst - 1 + N) % N) < bd) begin
                bd = (i - lst - 1 + N) % N;
                best = i;
            end
        return best;
    endfunction

    function automatic int gq_at(input int j);
        return gq.size() > j ? gq[j] : -1;
    endfunction

    task automatic tick();
        logic [N-1:0]     pr, e_gnt, e_done;
        logic [N*512-1:0] pd;
        logic [N*256-1:0] pc;
        logic [255:0]     ph;
        logic             psd;
        int               o;
        @(negedge clk);
        pr = req; psd = sha_done; ph = sha_hash; pd = req_data; pc = req_chain;
        e_gnt = '0; e_done = '0;
        if (!n_rst) begin
            m_ph = 0; m_last = N - 1; m_hash = '0; m_jd = '0; m_jc = '0; seen_en = 0;
        end else if (m_ph == 0) begin
            if (pr != '0) begin
                o = rr(pr, m_last);
                m_own = o; m_jd = pd[o*512 +: 512]; m_jc = pc[o*256 +: 256];
                e_gnt[o] = 1'b1; m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (psd) begin
                m_hash = ph; e_done[m_own] = 1'b1; m_last = m_own; m_ph = 2;
            end
        end else m_ph = 0;
        @(posedge clk); #1;
        chk("gnt", 512'(gnt), 512'(e_gnt));
        chk("done", 512'(done), 512'(e_done));
        chk("hash_out", 512'(hash_out), 512'(m_hash));
        chk("busy", 512'(busy), 512'(m_ph != 0));
        chk("sha_enable", 512'(sha_enable), 512'(m_ph == 1));
        if (m_ph == 1) begin
            chk("sha_data", sha_data, m_jd);
            chk("sha_current_hash", 512'(sha_current_hash), 512'(m_jc));
        end
        if (sha_enable) begin
            if (seen_en && low_cnt > 0) chk("enable_gap", 512'(low_cnt >= 2), 512'(1));
            seen_en = 1; low_cnt = 0;
        end else low_cnt++;
        for (int i = 0; i < N; i++)
            if (gnt_prev[i]) begin
                req[i] = 1'b0;
                req_data[i*512 +: 512] = '1;
            end
        gnt_prev = gnt;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin ngnt[i]++; gq.push_back(i); end
            if (done[i]) begin
                ndone[i]++;
                res[i] = hash_out;
                if (rearm[i]) begin
                    req[i] = 1'b1;
                    req_data[i*512 +: 512] = rnd512();
                end
            end
        end
    endtask

    task automatic wait_gnt(input int i);
        int s = ngnt[i];
        for (int k = 0; k < 200 && ngnt[i] == s; k++) tick();
        chk($sformatf("gnt_wait%0d", i), 512'(ngnt[i] - s), 512'(1));
    endtask

    task automatic wait_done(input int i);
        int s = ndone[i];
        for (int k = 0; k < 200 && ndone[i] == s; k++) tick();
        chk($sformatf("done_wait%0d", i), 512'(ndone[i] - s), 512'(1));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && (busy || req != '0); k++) tick();
        chk("idle", 512'(busy), 512'(0));
    endtask

    task automatic do_reset();
        n_rst = 1'b0; req = '0; gnt_prev = '0; rearm = '0;
        #1;
        chk("rst_gnt", 512'(gnt), '0);
        chk("rst_done", 512'(done), '0);
        chk("rst_hash_out", 512'(hash_out), '0);
        chk("rst_busy", 512'(busy), '0);
        chk("rst_sha_enable", 512'(sha_enable), '0);
        chk("rst_sha_data", sha_data, '0);
        chk("rst_sha_current_hash", 512'(sha_current_hash), '0);
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        logic [511:0] d;
        logic [255:0] c, h;
        req = '0; sp_done = 1'b0; sp_hash = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*512 +: 512] = rnd512();
            req_chain[i*256 +: 256] = rnd256();
        end
        n_rst = 1'b1;
        #2;
        do_reset();

        // single "abc" job on requester 2
        req_data[2*512 +: 512] = ABC; req_chain[2*256 +: 256] = IV; req[2] = 1'b1;
        wait_gnt(2);
        chk("t1_gnt", 512'(gnt), 512'(4'b0100));
        wait_done(2);
        chk("t1_done", 512'(done), 512'(4'b0100));
        chk("t1_hash", 512'(hash_out), 512'(ABC_H));
        tick();
        chk("t1_done_pulse", 512'(done), '0);
        wait_idle();

        // all requesters continuously requesting from reset
        do_reset();
        gq.delete();
        for (int i = 0; i < N; i++) begin
            req_data[i*512 +: 512] = rnd512();
            req_chain[i*256 +: 256] = rnd256();
        end
        rearm = '1; req = '1;
        for (int k = 0; k < 300 && gq.size() < 5; k++) tick();
        chk("t2_count", 512'(gq.size()), 512'(5));
        for (int j = 0; j < 5; j++) chk($sformatf("t2_order%0d", j), 512'(gq_at(j)), 512'(j % N));
        rearm = '0;
        wait_idle();

        // requester 1 overwrites its data after the grant
        d = rnd512(); c = rnd256();
        req_data[1*512 +: 512] = d; req_chain[1*256 +: 256] = c; req[1] = 1'b1;
        wait_gnt(1);
        wait_done(1);
        chk("t3_hash", 512'(res[1]), 512'(sha_compress(d, c)));
        wait_idle();

        // spurious sha_done while idle
        h = hash_out; sp_hash = rnd256(); sp_done = 1'b1;
        tick();
        sp_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("t4_done", 512'(done), '0);
            chk("t4_hash_hold", 512'(hash_out), 512'(h));
            chk("t4_idle", 512'(busy), '0);
            tick();
        end

        // reset while the core is running
        req_data[3*512 +: 512] = rnd512(); req[3] = 1'b1;
        for (int k = 0; k < 50 && !sha_enable; k++) tick();
        chk("t5_running", 512'(sha_enable), 512'(1));
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        gq.delete();
        req[0] = 1'b1; req[3] = 1'b1;
        wait_gnt(0);
        wait_gnt(3);
        chk("t5_first", 512'(gq_at(0)), 512'(0));
        chk("t5_second", 512'(gq_at(1)), 512'(3));
        wait_idle();
        do_reset();
        gq.delete();
        req[3] = 1'b1;
        wait_gnt(3);
        chk("t5_only3", 512'(gq_at(0)), 512'(3));
        wait_idle();

        // two-block chained message on requester 0, requester 1 in between
        gq.delete();
        req_data[0 +: 512] = M1; req_chain[0 +: 256] = IV; req[0] = 1'b1;
        wait_gnt(0);
        req_data[1*512 +: 512] = rnd512(); req_chain[1*256 +: 256] = rnd256(); req[1] = 1'b1;
        wait_done(0);
        req_data[0 +: 512] = M2; req_chain[0 +: 256] = res[0]; req[0] = 1'b1;
        wait_done(0);
        chk("t6_hash", 512'(res[0]), 512'(M_H));
        chk("t6_order0", 512'(gq_at(0)), 512'(0));
        chk("t6_order1", 512'(gq_at(1)), 512'(1));
        chk("t6_order2", 512'(gq_at(2)), 512'(0));
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
